// File: rtl/exec_adcx_mp_pkg.sv
// Shared definitions for the multi-precision add/subtract-with-carry unit.
package exec_adcx_mp_pkg;

  // Flag vector layout: {overflow, sign, zero, carry}
  localparam int unsigned W_FLAGS = 4;
  localparam int unsigned FLAG_C  = 0;
  localparam int unsigned FLAG_Z  = 1;
  localparam int unsigned FLAG_S  = 2;
  localparam int unsigned FLAG_V  = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/exec_adcx_limb.sv
// One limb of the add/subtract chain. Subtraction is a + ~b + cin; the
// overflow output is only meaningful when this is the most significant limb.
module exec_adcx_limb
  import exec_adcx_mp_pkg::*;
#(
  parameter int unsigned W_LIMB = 32
) (
  input  logic [W_LIMB-1:0] a_i,
  input  logic [W_LIMB-1:0] b_i,
  input  logic              minus_i,
  input  logic              cin_i,
  output logic [W_LIMB-1:0] sum_o,
  output logic              cout_o,
  output logic              ovf_o
);

  logic [W_LIMB-1:0] b_eff;
  logic [W_LIMB:0]   full;

  // Limb sum with carry out; overflow when equal-signed inputs give a differently signed sum
  always_comb begin
    b_eff  = minus_i ? ~b_i : b_i;
    full   = {1'b0, a_i} + {1'b0, b_eff} + {{W_LIMB{1'b0}}, cin_i};
    sum_o  = full[W_LIMB-1:0];
    cout_o = full[W_LIMB];
    ovf_o  = (a_i[W_LIMB-1] == b_eff[W_LIMB-1]) && (sum_o[W_LIMB-1] != a_i[W_LIMB-1]);
  end

endmodule

// File: rtl/exec_adcx_mp.sv
// Multi-precision ADC/SBC execution unit. Operands are captured on accept and
// processed one limb per cycle, LSB first; the result is held until taken.
module exec_adcx_mp #(
  parameter int unsigned W_LIMB  = 32,
  parameter int unsigned N_LIMBS = 4,
  parameter int unsigned W_FLAGS = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [N_LIMBS*W_LIMB-1:0] opr0_i,
  input  logic [N_LIMBS*W_LIMB-1:0] opr1_i,
  input  logic                      minus_i,
  input  logic                      use_carry_i,
  input  logic [W_FLAGS-1:0]        flags_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [N_LIMBS*W_LIMB-1:0] result_o,
  output logic [W_FLAGS-1:0]        flags_o
);
  import exec_adcx_mp_pkg::*;

  localparam int unsigned W_TOTAL = N_LIMBS * W_LIMB;
  localparam int unsigned CNT_W   = (N_LIMBS > 1) ? $clog2(N_LIMBS) : 1;
  localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(N_LIMBS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [W_TOTAL-1:0]  opr0_q, opr0_d;
  logic [W_TOTAL-1:0]  opr1_q, opr1_d;
  logic                minus_q, minus_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;
  logic [W_TOTAL-1:0]  res_q, res_d;
  logic [W_FLAGS-1:0]  flags_q, flags_d;

  logic [W_LIMB-1:0]   a_k, b_k, sum_k;
  logic                cout_k, ovf_k;

  // Only the carry/borrow bit of the incoming flags is consumed
  logic                unused_flags;
  assign unused_flags = ^flags_i[W_FLAGS-1:1];

  // Select the operand limbs addressed by the limb counter
  always_comb begin
    a_k = '0;
    b_k = '0;
    for (int i = 0; i < int'(N_LIMBS); i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_k = opr0_q[i*W_LIMB +: W_LIMB];
        b_k = opr1_q[i*W_LIMB +: W_LIMB];
      end
    end
  end

  exec_adcx_limb #(
    .W_LIMB (W_LIMB)
  ) u_limb (
    .a_i     (a_k),
    .b_i     (b_k),
    .minus_i (minus_q),
    .cin_i   (carry_q),
    .sum_o   (sum_k),
    .cout_o  (cout_k),
    .ovf_o   (ovf_k)
  );

  // FSM next state and datapath register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opr0_d  = opr0_q;
    opr1_d  = opr1_q;
    minus_d = minus_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    res_d   = res_q;
    flags_d = flags_q;

    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          opr0_d  = opr0_i;
          opr1_d  = opr1_i;
          minus_d = minus_i;
          // Subtraction is a + ~b + 1, so an incoming borrow cancels the +1
          carry_d = minus_i ^ (use_carry_i & flags_i[0]);
          cnt_d   = '0;
          res_d   = '0;
          zero_d  = 1'b1;
          state_d = StRun;
        end
      end

      StRun: begin
        carry_d = cout_k;
        zero_d  = zero_q & (sum_k == '0);
        for (int i = 0; i < int'(N_LIMBS); i++) begin
          if (cnt_q == CNT_W'(i)) begin
            res_d[i*W_LIMB +: W_LIMB] = sum_k;
          end
        end
        if (cnt_q == LAST_LIMB) begin
          flags_d         = '0;
          flags_d[FLAG_C] = minus_q ^ cout_k;
          flags_d[FLAG_Z] = zero_d;
          flags_d[FLAG_S] = sum_k[W_LIMB-1];
          flags_d[FLAG_V] = ovf_k;
          cnt_d           = '0;
          state_d         = StDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      StDone: begin
        if (res_ready_i) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      opr0_q  <= '0;
      opr1_q  <= '0;
      minus_q <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opr0_q  <= opr0_d;
      opr1_q  <= opr1_d;
      minus_q <= minus_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign res_valid_o = (state_q == StDone);
  assign result_o    = res_q;
  assign flags_o     = flags_q;

endmodule

// File: doc/exec_adcx_mp.md
Name: exec_adcx_mp

Overview:
- Multi-precision add/subtract-with-carry execution unit for the exec stage.
- Operands are N_LIMBS*W_LIMB bits wide and are processed one W_LIMB limb per cycle, LSB limb first, with the carry/borrow chained between limbs.
- Produces the full-width result plus the standard 4-bit flags {overflow, sign, zero, carry}.
- Accepts a request over a valid/ready handshake and holds the result until the consumer accepts it.

Parameters:
- W_LIMB, 32, limb width in bits; minimum 2.
- N_LIMBS, 4, number of limbs per operand; minimum 1.
- W_FLAGS, 4, flag vector width; fixed at 4.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_n_i  in  1  reset: one clock, synchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit can accept a request.
- opr0_i  in  N_LIMBS*W_LIMB  first operand.
- opr1_i  in  N_LIMBS*W_LIMB  second operand.
- minus_i  in  1  0 = add, 1 = subtract (opr0 - opr1).
- use_carry_i  in  1  1 = take carry/borrow-in from flags_i[0]; 0 = carry-in is 0 (add) or no borrow (sub).
- flags_i  in  W_FLAGS  incoming flags; only bit 0 is used.
- res_valid_o  out  1  result and flags valid.
- res_ready_i  in  1  consumer accepts the result.
- result_o  out  N_LIMBS*W_LIMB  result.
- flags_o  out  W_FLAGS  {overflow, sign, zero, carry}.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst_n_i sampled low at the clock edge) forces IDLE from any state, including mid-RUN, and:
  - res_valid_o = 0, result_o = 0, flags_o = 0, limb counter = 0;
  - req_ready_o = 1 combinationally while in IDLE.
- Accept: in IDLE, req_valid_i && req_ready_o at an edge.
  - Registers opr0, opr1, minus and the carry-in bit.
  - Carry-in bit c = use_carry_i ? flags_i[0] : 0, where flags_i[0] means carry for add and borrow for sub.
  - Clears the result register and the zero accumulator, then goes to RUN.
  - Operands are captured; later changes on the inputs have no effect.
- RUN: cycle k (k = 0..N_LIMBS-1) computes limb k.
  - Add: limb sum = a_k + b_k + cin.
  - Sub: limb sum = a_k + ~b_k + cin. Internal cin for limb 0 = minus ^ c; for later limbs cin = the raw carry out of limb k-1.
  - Writes result limb k; zero_acc &= (limb_k == 0).
  - After limb N_LIMBS-1, go to DONE. Latency from accept edge to res_valid_o = N_LIMBS cycles.
- DONE: res_valid_o = 1. result_o and flags_o are stable until the handshake.
  - res_ready_i high at an edge: go to IDLE, res_valid_o falls the next cycle. Earliest new accept is the edge after.
  - Back-to-back throughput: one op per N_LIMBS+2 cycles.
- Flags:
  - carry = raw carry out of the top limb for add; inverted (a borrow) for sub. Input and output use the same convention.
  - sign = result MSB.
  - zero = 1 iff all N_LIMBS*W_LIMB result bits are 0.
  - overflow = signed overflow of the full-width operation: operands effectively of equal sign (after the ~b for sub) and result sign differs from opr0 MSB.
- All arithmetic is modulo 2^(N_LIMBS*W_LIMB). With N_LIMBS = 1 the unit behaves as a single-limb ADC/SBC with 1-cycle latency.
- req_valid_i asserted outside IDLE is ignored (req_ready_o = 0). The requester must hold it.

Decomposition:
- Shared package holds:
  - flag bit indices FLAG_C = 0, FLAG_Z = 1, FLAG_S = 2, FLAG_V = 3;
  - W_FLAGS;
  - the state encoding (IDLE, RUN, DONE).
- One combinational sub-module, exec_adcx_limb (W_LIMB wide):
  - inputs a, b, minus, cin;
  - outputs sum, cout, and per-limb overflow, taken only from the top limb.
- Top level holds the FSM, limb counter, operand shift/index logic, result register and zero accumulator.

Test Plan (W_LIMB=8, N_LIMBS=4):
- Add with carry chain: 0x000000FF + 0x00000001, use_carry=0 -> result 0x00000100, flags 0000. res_valid_o rises exactly 4 cycles after accept.
- Full wrap: 0xFFFFFFFF + 0x00000001 -> result 0x00000000, flags 0011 (Z=1, C=1). Then 0x7FFFFFFF + 1 -> 0x80000000, flags 1100 (V=1, S=1).
- Subtract with borrow: 0x00000000 - 0x00000001, use_carry=0 -> 0xFFFFFFFF, flags 0101 (S=1, C=borrow=1). Same op with use_carry=1, flags_i[0]=1 -> 0xFFFFFFFE, flags 0101.
- Chained ADC: 0x00000005 + 0x00000003, use_carry=1, flags_i=0001 -> 0x00000009, flags 0000.
- Backpressure: hold res_ready_i=0 for 10 cycles -> result/flags stable, req_ready_o=0. Toggle the operand inputs during RUN -> result unaffected.
- Reset mid-RUN: rst_n_i low at cycle 2 of RUN -> next cycle IDLE, res_valid_o=0, result_o=0, flags_o=0. A subsequent op completes correctly.
